// File: rtl/pcie_rx_cond_pkg.sv
// Shared definitions for the PCIe-style two-lane link conditioners.
// Holds the comma symbol, the default lock count and the receive FSM encoding.
package pcie_rx_cond_pkg;

  localparam logic [7:0]  COMMA_DEF    = 8'hBC;
  localparam int unsigned BC_COUNT_DEF = 4;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/pcie_rx_cond_s2p.sv
// Serial-to-parallel front end: shift register, byte-phase counter, comma compare.
// Ports:
//   clk_8f, reset   bit clock, synchronous active-low reset
//   data_in         serial bit, MSB first
//   realign         restart byte phase (bit counter to 0) on this edge
//   nxt_c           byte formed by the 7 stored bits plus the current bit
//   boundary_c      this edge completes a byte
//   comma_hit_c     nxt_c equals the comma symbol
module pcie_rx_cond_s2p
  import pcie_rx_cond_pkg::*;
#(
  parameter logic [7:0] COMMA = COMMA_DEF
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  input  logic       realign,
  output logic [7:0] nxt_c,
  output logic       boundary_c,
  output logic       comma_hit_c
);

  // Only the 7 most recent bits need storing; the 8th is the live input.
  logic [6:0] sr;
  logic [2:0] bit_cnt;

  assign nxt_c       = {sr, data_in};
  assign comma_hit_c = (nxt_c == COMMA);
  assign boundary_c  = (bit_cnt == 3'd7);

  // Shift every cycle; the counter wraps 7->0 naturally.
  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      sr      <= 7'd0;
      bit_cnt <= 3'd0;
    end else begin
      sr      <= nxt_c[6:0];
      bit_cnt <= realign ? 3'd0 : bit_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/pcie_rx_cond.sv
// Receive conditioner: comma alignment, byte deserialization, lane un-striping.
// Ports:
//   clk_8f, reset                 bit clock, synchronous active-low reset
//   data_in                       serial bit stream, MSB first
//   data_out_0_c / valid_out_0_c  lane 0 byte and valid (even bytes after lock)
//   data_out_1_c / valid_out_1_c  lane 1 byte and valid (odd bytes after lock)
//   active                        alignment locked
//   byte_strobe                   one-cycle pulse per byte boundary while active
module pcie_rx_cond
  import pcie_rx_cond_pkg::*;
#(
  parameter logic [7:0]  COMMA    = COMMA_DEF,
  parameter int unsigned BC_COUNT = BC_COUNT_DEF
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out_0_c,
  output logic       valid_out_0_c,
  output logic [7:0] data_out_1_c,
  output logic       valid_out_1_c,
  output logic       active,
  output logic       byte_strobe
);

  localparam int unsigned BC_W = $clog2(BC_COUNT + 1);

  rx_state_e   state;
  logic [BC_W-1:0] bc_cnt;
  logic        sel;
  logic [7:0]  nxt;
  logic        boundary;
  logic        comma_hit;
  logic        realign;

  // A comma seen while searching fixes the byte phase from this bit onward.
  assign realign = (state == ST_SEARCH) && comma_hit;

  pcie_rx_cond_s2p #(.COMMA(COMMA)) u_s2p (
    .clk_8f      (clk_8f),
    .reset       (reset),
    .data_in     (data_in),
    .realign     (realign),
    .nxt_c       (nxt),
    .boundary_c  (boundary),
    .comma_hit_c (comma_hit)
  );

  // Alignment FSM plus lane output registers.
  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      state         <= ST_SEARCH;
      bc_cnt        <= '0;
      sel           <= 1'b0;
      active        <= 1'b0;
      byte_strobe   <= 1'b0;
      data_out_0_c  <= 8'd0;
      valid_out_0_c <= 1'b0;
      data_out_1_c  <= 8'd0;
      valid_out_1_c <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      case (state)
        ST_SEARCH: begin
          if (comma_hit) begin
            bc_cnt <= BC_W'(1);
            state  <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (boundary) begin
            if (comma_hit) begin
              bc_cnt <= bc_cnt + BC_W'(1);
              if (bc_cnt == BC_W'(BC_COUNT - 1)) begin
                state  <= ST_ACTIVE;
                sel    <= 1'b0;
                active <= 1'b1;
              end
            end else begin
              bc_cnt <= '0;
              state  <= ST_SEARCH;
            end
          end
        end
        ST_ACTIVE: begin
          // Idle bytes still consume a lane slot; only the addressed lane changes.
          if (boundary) begin
            byte_strobe <= 1'b1;
            sel         <= ~sel;
            if (!sel) begin
              valid_out_0_c <= !comma_hit;
              if (!comma_hit) data_out_0_c <= nxt;
            end else begin
              valid_out_1_c <= !comma_hit;
              if (!comma_hit) data_out_1_c <= nxt;
            end
          end
        end
        default: state <= ST_SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_rx_cond.sv
module tb_pcie_rx_cond;

  localparam logic [7:0] COMMA = 8'hBC;

  logic       clk_8f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out_0_c;
  logic       valid_out_0_c;
  logic [7:0] data_out_1_c;
  logic       valid_out_1_c;
  logic       active;
  logic       byte_strobe;

  int n_checks = 0;
  int n_errors = 0;

  pcie_rx_cond dut (
    .clk_8f        (clk_8f),
    .reset         (reset),
    .data_in       (data_in),
    .data_out_0_c  (data_out_0_c),
    .valid_out_0_c (valid_out_0_c),
    .data_out_1_c  (data_out_1_c),
    .valid_out_1_c (valid_out_1_c),
    .active        (active),
    .byte_strobe   (byte_strobe)
  );

  initial clk_8f = 1'b0;
  always #5 clk_8f = ~clk_8f;

  // Behavioural model: last-8-bit window, lock anchor, byte index since lock.
  int         m_win;
  int         m_mode;     // 0 searching, 1 counting commas, 2 locked
  longint     m_cyc;
  longint     m_anchor;
  int         m_commas;
  int         m_bytes;
  logic [7:0] e_d0, e_d1;
  logic       e_v0, e_v1, e_act, e_stb;

  task automatic model_clear();
    m_win = 0; m_mode = 0; m_cyc = 0; m_anchor = 0; m_commas = 0; m_bytes = 0;
    e_d0 = 8'd0; e_d1 = 8'd0; e_v0 = 1'b0; e_v1 = 1'b0; e_act = 1'b0; e_stb = 1'b0;
  endtask

  task automatic model_step();
    bit on_byte;
    if (!reset) begin
      model_clear();
    end else begin
      m_cyc++;
      m_win = ((m_win << 1) | int'(data_in)) & 255;
      e_stb = 1'b0;
      on_byte = ((m_cyc - m_anchor) % 8) == 0;
      if (m_mode == 0) begin
        if (m_win == int'(COMMA)) begin
          m_anchor = m_cyc; m_commas = 1; m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (on_byte) begin
          if (m_win == int'(COMMA)) begin
            m_commas++;
            if (m_commas == 4) begin
              m_mode = 2; e_act = 1'b1; m_bytes = 0;
            end
          end else begin
            m_mode = 0; m_commas = 0;
          end
        end
      end else begin
        if (on_byte) begin
          e_stb = 1'b1;
          if (m_bytes % 2 == 0) begin
            if (m_win == int'(COMMA)) e_v0 = 1'b0;
            else begin e_d0 = 8'(m_win); e_v0 = 1'b1; end
          end else begin
            if (m_win == int'(COMMA)) e_v1 = 1'b0;
            else begin e_d1 = 8'(m_win); e_v1 = 1'b1; end
          end
          m_bytes++;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk_8f);
      model_step();
    end
  end

  // Compare every cycle, 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk_8f);
      #1;
      check("data0",  data_out_0_c,        e_d0);
      check("valid0", 8'(valid_out_0_c),   8'(e_v0));
      check("data1",  data_out_1_c,        e_d1);
      check("valid1", 8'(valid_out_1_c),   8'(e_v1));
      check("active", 8'(active),          8'(e_act));
      check("strobe", 8'(byte_strobe),     8'(e_stb));
    end
  end

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_8f);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) send_bit(1'($urandom % 2));
    reset = 1'b1;
  endtask

  task automatic lock();
    for (int i = 0; i < 4; i++) send_byte(COMMA);
  endtask

  logic [7:0] pool [4];

  initial begin
    reset   = 1'b0;
    data_in = 1'b0;
    pool[0] = 8'h00; pool[1] = 8'hFF; pool[2] = 8'h55; pool[3] = 8'hAA;

    // Reset with random input.
    do_reset(3);
    check("rst_active", 8'(active), 8'd0);
    check("rst_d0", data_out_0_c, 8'd0);
    check("rst_v1", 8'(valid_out_1_c), 8'd0);

    // Garbage bits, then lock.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_byte(COMMA); send_byte(COMMA); send_byte(COMMA);
    for (int i = 7; i >= 1; i--) send_bit(COMMA[i]);
    check("pre_lock_active", 8'(active), 8'd0);
    send_bit(COMMA[0]);
    check("lock_active", 8'(active), 8'd1);
    check("lock_v0", 8'(valid_out_0_c), 8'd0);
    check("lock_d1", data_out_1_c, 8'd0);

    // Striping of FF,EE,DD,CC.
    send_byte(8'hFF);
    check("ff_d0", data_out_0_c, 8'hFF);
    check("ff_v0", 8'(valid_out_0_c), 8'd1);
    check("ff_strobe", 8'(byte_strobe), 8'd1);
    send_byte(8'hEE);
    check("ee_d1", data_out_1_c, 8'hEE);
    send_byte(8'hDD);
    check("dd_d0", data_out_0_c, 8'hDD);
    check("dd_d1_held", data_out_1_c, 8'hEE);
    send_byte(8'hCC);
    check("cc_d1", data_out_1_c, 8'hCC);
    check("cc_v1", 8'(valid_out_1_c), 8'd1);

    // One-cycle reset mid-stream.
    do_reset(1);
    check("mid_rst_active", 8'(active), 8'd0);
    check("mid_rst_d0", data_out_0_c, 8'd0);
    check("mid_rst_v1", 8'(valid_out_1_c), 8'd0);

    // Idle byte on lane 1.
    lock();
    check("relock_active", 8'(active), 8'd1);
    send_byte(8'h11);
    check("x11_d0", data_out_0_c, 8'h11);
    send_byte(COMMA);
    check("idle_v1", 8'(valid_out_1_c), 8'd0);
    check("idle_d1", data_out_1_c, 8'h00);
    send_byte(8'h22);
    check("x22_d0", data_out_0_c, 8'h22);
    send_byte(8'h33);
    check("x33_d1", data_out_1_c, 8'h33);
    check("x33_v1", 8'(valid_out_1_c), 8'd1);

    // Broken comma run falls back to search.
    do_reset(2);
    send_byte(COMMA); send_byte(COMMA); send_byte(COMMA);
    send_byte(8'h55);
    check("broken_active", 8'(active), 8'd0);
    lock();
    check("after_broken_active", 8'(active), 8'd1);

    // Comma-free stream after reset never locks.
    do_reset(1);
    for (int i = 0; i < 20; i++) send_byte(pool[$urandom % 4]);
    check("nocomma_active", 8'(active), 8'd0);

    // Random mix of commas, data, phase slips and resets.
    for (int it = 0; it < 300; it++) begin
      int r;
      r = int'($urandom % 16);
      if (r == 0) do_reset(1);
      else if (r < 3) begin
        int nb;
        nb = int'($urandom_range(7, 1));
        for (int k = 0; k < nb; k++) send_bit(1'($urandom % 2));
      end else if (r < 9) send_byte(COMMA);
      else send_byte(8'($urandom));
    end

    send_bit(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
